// File: rtl/alu_b_stage_if.sv
// Control/status bundle between the SAP-1 sequencer, the A register and the B/ALU stage.
// The shared W bus itself stays a plain inout on the stage.
interface alu_b_stage_if #(
  parameter int WIDTH = 8
);
  logic             load_b;
  logic             sub;
  logic             latch;
  logic             enable;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_out;
  logic             carry_flag;
  logic             zero_flag;
  logic             bus_oe;   // W bus driver enable, so observers need not sense Z

  modport master (
    output load_b, sub, latch, enable, a_in,
    input  b_out, carry_flag, zero_flag, bus_oe
  );

  modport slave (
    input  load_b, sub, latch, enable, a_in,
    output b_out, carry_flag, zero_flag, bus_oe
  );
endinterface

// File: rtl/alu_b_stage.sv
// SAP-1 B register plus adder/subtractor with registered result and flags.
// The registered result is driven back onto the tri-state W bus on request.
module alu_b_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_b_stage_if.slave     ctl,
  inout  wire [WIDTH-1:0]  w_bus
);

  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             zero_q,   zero_d;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;
  logic             drive_en;

  // Subtraction is A + ~B + 1, so carry out set means "no borrow".
  always_comb begin
    operand = ctl.sub ? ~b_q : b_q;
    sum     = {1'b0, ctl.a_in} + {1'b0, operand} + {{WIDTH{1'b0}}, ctl.sub};
  end

  always_comb begin
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    if (ctl.load_b) begin
      b_d = w_bus;
    end
    if (ctl.latch) begin
      result_d = sum[WIDTH-1:0];
      carry_d  = sum[WIDTH];
      zero_d   = (sum[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Reset level gates the driver so the bus floats at once, not at the next edge.
  assign drive_en       = ctl.enable & reset;
  assign w_bus          = drive_en ? result_q : {WIDTH{1'bz}};
  assign ctl.bus_oe     = drive_en;
  assign ctl.b_out      = b_q;
  assign ctl.carry_flag = carry_q;
  assign ctl.zero_flag  = zero_q;

endmodule
